csr_regfile: RTL and testbench

Machine-mode CSR register file and trap unit; the responder to the decode controller's `csr_wr_req`, `csr_reg_rd` and `is_mret` requests. It sits beside the MEM stage and serves CSRRW reads and writes. It also synchronises the timer and external interrupt lines, takes interrupt traps, and executes MRET. On either event it drives a registered PC redirect (`epc_taken`, `excp_pc`) back to the fetch stage.

---
 rtl/csr_regfile.sv | 163 ++++++++++++++++
 tb/tb_csr_regfile.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: mstatus/mie/mtvec/mepc/mcause/mip, interrupt trap entry
// and MRET, with a registered one-cycle PC redirect to fetch.
module csr_regfile #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_csr_wr_req,
  input  logic            i_csr_reg_rd,
  input  logic            i_is_mret,
  input  logic            i_instr_valid,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_timer_intr,
  input  logic            i_ext_intr,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_epc_taken,
  output logic [XLEN-1:0] o_excp_pc
);

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMie     = 12'h304;
  localparam logic [11:0] AddrMtvec   = 12'h305;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;
  localparam logic [11:0] AddrMip     = 12'h344;

  typedef enum logic {StRun, StRedirect} state_e;

  state_e          r_state, w_state_nxt;
  logic            r_mstatus_mie, w_mstatus_mie_nxt;
  logic            r_mstatus_mpie, w_mstatus_mpie_nxt;
  logic            r_mtie, w_mtie_nxt;
  logic            r_meie, w_meie_nxt;
  logic [XLEN-1:0] r_mtvec, w_mtvec_nxt;
  logic [XLEN-1:0] r_mepc, w_mepc_nxt;
  logic [XLEN-1:0] r_mcause, w_mcause_nxt;
  logic [1:0]      r_tsync, r_esync;
  logic            r_epc_taken, w_epc_taken_nxt;
  logic [XLEN-1:0] r_excp_pc, w_excp_pc_nxt;

  logic [XLEN-1:0] w_mstatus, w_mie, w_mip;
  logic            w_take_irq, w_ext_sel;
  logic [4:0]      w_cause_code;
  logic [XLEN-1:0] w_trap_base, w_trap_pc, w_trap_cause;

  assign w_mstatus = {{(XLEN-8){1'b0}}, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000};
  assign w_mie     = {{(XLEN-12){1'b0}}, r_meie, 3'b000, r_mtie, 7'b0000000};
  assign w_mip     = {{(XLEN-12){1'b0}}, r_esync[1], 3'b000, r_tsync[1], 7'b0000000};

  // A same-cycle CSR write or MRET defers the interrupt so their updates never collide.
  assign w_take_irq = r_mstatus_mie & i_instr_valid & ~i_csr_wr_req & ~i_is_mret &
                      (|(w_mip & w_mie));

  assign w_ext_sel    = r_esync[1] & r_meie;
  assign w_cause_code = w_ext_sel ? 5'd11 : 5'd7;
  assign w_trap_cause = {1'b1, {(XLEN-6){1'b0}}, w_cause_code};
  assign w_trap_base  = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_trap_pc    = r_mtvec[0] ? w_trap_base + {{(XLEN-7){1'b0}}, w_cause_code, 2'b00}
                                   : w_trap_base;

  always_comb begin
    o_csr_rdata = '0;
    if (i_csr_reg_rd) begin
      case (i_csr_addr)
        AddrMstatus: o_csr_rdata = w_mstatus;
        AddrMie:     o_csr_rdata = w_mie;
        AddrMtvec:   o_csr_rdata = r_mtvec;
        AddrMepc:    o_csr_rdata = r_mepc;
        AddrMcause:  o_csr_rdata = r_mcause;
        AddrMip:     o_csr_rdata = w_mip;
        default:     o_csr_rdata = '0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_mstatus_mie_nxt  = r_mstatus_mie;
    w_mstatus_mpie_nxt = r_mstatus_mpie;
    w_mtie_nxt         = r_mtie;
    w_meie_nxt         = r_meie;
    w_mtvec_nxt        = r_mtvec;
    w_mepc_nxt         = r_mepc;
    w_mcause_nxt       = r_mcause;
    w_epc_taken_nxt    = 1'b0;
    w_excp_pc_nxt      = r_excp_pc;

    if (i_csr_wr_req) begin
      case (i_csr_addr)
        AddrMstatus: begin
          w_mstatus_mie_nxt  = i_csr_wdata[3];
          w_mstatus_mpie_nxt = i_csr_wdata[7];
        end
        AddrMie: begin
          w_mtie_nxt = i_csr_wdata[7];
          w_meie_nxt = i_csr_wdata[11];
        end
        AddrMtvec:  w_mtvec_nxt  = {i_csr_wdata[XLEN-1:2], 1'b0, i_csr_wdata[0]};
        AddrMepc:   w_mepc_nxt   = {i_csr_wdata[XLEN-1:2], 2'b00};
        AddrMcause: w_mcause_nxt = i_csr_wdata;
        default: ;
      endcase
    end

    case (r_state)
      StRun: begin
        if (i_is_mret && i_instr_valid) begin
          w_mstatus_mie_nxt  = r_mstatus_mpie;
          w_mstatus_mpie_nxt = 1'b1;
          w_epc_taken_nxt    = 1'b1;
          w_excp_pc_nxt      = r_mepc;
          w_state_nxt        = StRedirect;
        end else if (w_take_irq) begin
          w_mepc_nxt         = i_pc;
          w_mcause_nxt       = w_trap_cause;
          w_mstatus_mpie_nxt = r_mstatus_mie;
          w_mstatus_mie_nxt  = 1'b0;
          w_epc_taken_nxt    = 1'b1;
          w_excp_pc_nxt      = w_trap_pc;
          w_state_nxt        = StRedirect;
        end
      end
      StRedirect: w_state_nxt = StRun;
      default:    w_state_nxt = StRun;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StRun;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mtie         <= 1'b0;
      r_meie         <= 1'b0;
      r_mtvec        <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_tsync        <= '0;
      r_esync        <= '0;
      r_epc_taken    <= 1'b0;
      r_excp_pc      <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_mstatus_mie  <= w_mstatus_mie_nxt;
      r_mstatus_mpie <= w_mstatus_mpie_nxt;
      r_mtie         <= w_mtie_nxt;
      r_meie         <= w_meie_nxt;
      r_mtvec        <= w_mtvec_nxt;
      r_mepc         <= w_mepc_nxt;
      r_mcause       <= w_mcause_nxt;
      r_tsync        <= {r_tsync[0], i_timer_intr};
      r_esync        <= {r_esync[0], i_ext_intr};
      r_epc_taken    <= w_epc_taken_nxt;
      r_excp_pc      <= w_excp_pc_nxt;
    end
  end

  assign o_epc_taken = r_epc_taken;
  assign o_excp_pc   = r_excp_pc;

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboard bench for csr_regfile: stimulus queues expected read data and redirect targets,
// a negedge monitor pops and compares them whenever the DUT presents a read or a redirect.
module tb_csr_regfile;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_csr_wr_req = 1'b0;
  logic        i_csr_reg_rd = 1'b0;
  logic        i_is_mret = 1'b0;
  logic        i_instr_valid = 1'b0;
  logic [11:0] i_csr_addr = '0;
  logic [31:0] i_csr_wdata = '0;
  logic [31:0] i_pc = '0;
  logic        i_timer_intr = 1'b0;
  logic        i_ext_intr = 1'b0;
  logic [31:0] o_csr_rdata;
  logic        o_epc_taken;
  logic [31:0] o_excp_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_exp_q[$];
  logic [11:0] rd_addr_q[$];
  logic [31:0] redir_q[$];

  csr_regfile #(.XLEN(32)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_csr_wr_req  (i_csr_wr_req),
    .i_csr_reg_rd  (i_csr_reg_rd),
    .i_is_mret     (i_is_mret),
    .i_instr_valid (i_instr_valid),
    .i_csr_addr    (i_csr_addr),
    .i_csr_wdata   (i_csr_wdata),
    .i_pc          (i_pc),
    .i_timer_intr  (i_timer_intr),
    .i_ext_intr    (i_ext_intr),
    .o_csr_rdata   (o_csr_rdata),
    .o_epc_taken   (o_epc_taken),
    .o_excp_pc     (o_excp_pc)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every presented read and every redirect strobe must match a queued expectation.
  always @(negedge i_clk) begin
    if (i_rst_n && o_epc_taken) begin
      if (redir_q.size() == 0) check("unexpected_redirect", 32'd1, 32'd0);
      else check("redirect_pc", o_excp_pc, redir_q.pop_front());
    end
    if (i_csr_reg_rd) begin
      if (rd_exp_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
      else check($sformatf("read_%03h", rd_addr_q.pop_front()), o_csr_rdata,
                 rd_exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    i_csr_addr   = addr;
    i_csr_wdata  = data;
    i_csr_wr_req = 1'b1;
    step();
    i_csr_wr_req = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] addr, input logic [31:0] exp);
    i_csr_addr   = addr;
    i_csr_reg_rd = 1'b1;
    rd_addr_q.push_back(addr);
    rd_exp_q.push_back(exp);
    step();
    i_csr_reg_rd = 1'b0;
  endtask

  task automatic csr_rw(input logic [11:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_old);
    i_csr_addr   = addr;
    i_csr_wdata  = data;
    i_csr_wr_req = 1'b1;
    i_csr_reg_rd = 1'b1;
    rd_addr_q.push_back(addr);
    rd_exp_q.push_back(exp_old);
    step();
    i_csr_wr_req = 1'b0;
    i_csr_reg_rd = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (redir_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    if (redir_q.size() != 0) begin
      check("redirect_timeout", redir_q.size(), 32'd0);
      redir_q.delete();
    end
  endtask

  task automatic read_all_zero();
    csr_read(12'h300, 32'h0);
    csr_read(12'h304, 32'h0);
    csr_read(12'h305, 32'h0);
    csr_read(12'h341, 32'h0);
    csr_read(12'h342, 32'h0);
    csr_read(12'h344, 32'h0);
  endtask

  initial begin
    #1;
    check("reset_epc_taken", {31'd0, o_epc_taken}, 32'd0);
    check("reset_excp_pc", o_excp_pc, 32'd0);
    step();
    step();
    i_rst_n = 1'b1;
    step();
    read_all_zero();

    // CSR masks and read-old-on-write
    csr_write(12'h305, 32'h8000_0103);
    csr_read(12'h305, 32'h8000_0101);
    csr_write(12'h300, 32'hFFFF_FFFF);
    csr_read(12'h300, 32'h0000_0088);
    csr_write(12'h300, 32'h0);
    csr_write(12'h344, 32'hFFFF_FFFF);
    csr_read(12'h344, 32'h0);
    csr_write(12'h304, 32'hFFFF_FFFF);
    csr_read(12'h304, 32'h0000_0880);
    csr_write(12'h341, 32'hFFFF_FFFF);
    csr_read(12'h341, 32'hFFFF_FFFC);
    csr_rw(12'h342, 32'h1234_5678, 32'h0);
    csr_read(12'h342, 32'h1234_5678);
    csr_write(12'h123, 32'hDEAD_BEEF);
    csr_read(12'h123, 32'h0);

    // Direct-mode timer trap, exact latency
    csr_write(12'h305, 32'h0000_0100);
    csr_write(12'h304, 32'h0000_0080);
    csr_write(12'h300, 32'h0000_0008);
    i_pc = 32'h240;
    i_instr_valid = 1'b1;
    i_timer_intr = 1'b1;
    redir_q.push_back(32'h100);
    step();
    step();
    check("timer_lat_edge2", {31'd0, o_epc_taken}, 32'd0);
    step();
    check("timer_lat_edge3", {31'd0, o_epc_taken}, 32'd1);
    check("timer_lat_pc", o_excp_pc, 32'h100);
    i_instr_valid = 1'b0;
    wait_drain();
    csr_read(12'h344, 32'h0000_0080);
    csr_read(12'h341, 32'h0000_0240);
    csr_read(12'h342, 32'h8000_0007);
    csr_read(12'h300, 32'h0000_0080);
    i_timer_intr = 1'b0;
    repeat (3) step();

    // Vectored mode, external beats timer
    csr_write(12'h305, 32'h0000_0201);
    csr_write(12'h304, 32'h0000_0880);
    csr_write(12'h300, 32'h0000_0008);
    i_pc = 32'h300;
    i_instr_valid = 1'b1;
    i_timer_intr = 1'b1;
    i_ext_intr = 1'b1;
    redir_q.push_back(32'h22C);
    wait_drain();
    i_instr_valid = 1'b0;
    csr_read(12'h342, 32'h8000_000B);
    csr_read(12'h341, 32'h0000_0300);
    csr_read(12'h300, 32'h0000_0080);
    i_timer_intr = 1'b0;
    i_ext_intr = 1'b0;
    repeat (3) step();

    // MRET
    csr_write(12'h341, 32'h0000_0244);
    csr_write(12'h300, 32'h0000_0080);
    i_is_mret = 1'b1;
    i_instr_valid = 1'b1;
    redir_q.push_back(32'h244);
    step();
    i_is_mret = 1'b0;
    i_instr_valid = 1'b0;
    wait_drain();
    csr_read(12'h300, 32'h0000_0088);

    // Pending interrupt: no trap without a valid instruction, deferred by a CSR write
    csr_write(12'h305, 32'h0000_0100);
    i_timer_intr = 1'b1;
    repeat (4) step();
    csr_read(12'h344, 32'h0000_0080);
    i_pc = 32'h400;
    i_instr_valid = 1'b1;
    csr_write(12'h342, 32'h0000_0055);
    redir_q.push_back(32'h100);
    step();
    i_instr_valid = 1'b0;
    wait_drain();
    csr_read(12'h342, 32'h8000_0007);
    csr_read(12'h341, 32'h0000_0400);

    // MRET beats a qualified pending interrupt, which is then taken afterwards
    csr_write(12'h300, 32'h0000_0088);
    i_pc = 32'h500;
    i_is_mret = 1'b1;
    i_instr_valid = 1'b1;
    redir_q.push_back(32'h400);
    step();
    i_is_mret = 1'b0;
    redir_q.push_back(32'h100);
    step();
    step();
    i_instr_valid = 1'b0;
    wait_drain();
    csr_read(12'h341, 32'h0000_0500);
    csr_read(12'h300, 32'h0000_0080);

    // Asynchronous reset during REDIRECT
    i_is_mret = 1'b1;
    i_instr_valid = 1'b1;
    step();
    i_is_mret = 1'b0;
    i_instr_valid = 1'b0;
    check("pre_reset_epc_taken", {31'd0, o_epc_taken}, 32'd1);
    check("pre_reset_excp_pc", o_excp_pc, 32'h500);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_epc_taken", {31'd0, o_epc_taken}, 32'd0);
    check("async_rst_excp_pc", o_excp_pc, 32'd0);
    i_timer_intr = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    step();
    read_all_zero();

    repeat (2) step();
    check("read_queue_empty", rd_exp_q.size(), 32'd0);
    check("redirect_queue_empty", redir_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
